// File: rtl/wdt_kicker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wdt_kicker: pets an external watchdog while software heartbeats,     |
// | stops on heartbeat starvation, faults after too many watchdog irqs.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module wdt_kicker #(
    parameter int unsigned KICK_PERIOD_CNT = 50000000,
    parameter int unsigned HB_TIMEOUT_CNT  = 200000000,
    parameter int unsigned IRQ_LIMIT       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       heartbeat,
    input  logic       irq,
    output logic       pet,
    output logic [1:0] state,
    output logic [7:0] irq_count,
    output logic       fault
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        STARVED = 2'd2,
        FAULT   = 2'd3
    } state_t;

    localparam logic [31:0] C_KICK_LAST = 32'(KICK_PERIOD_CNT - 1);
    localparam logic [31:0] C_HB_LAST   = 32'(HB_TIMEOUT_CNT - 1);
    localparam logic [7:0]  C_IRQ_LIMIT = 8'(IRQ_LIMIT);

    state_t      r_state;
    logic [31:0] r_kick_cnt;
    logic [31:0] r_hb_cnt;
    logic        r_irq_d;

    logic        w_live;
    logic        w_irq_edge;
    logic [7:0]  w_irq_inc;
    logic        w_to_fault;
    logic        w_kick_last;
    logic        w_hb_expire;

    assign state       = r_state;
    assign w_live      = (r_state == ARMED) || (r_state == STARVED);
    assign w_irq_edge  = irq & ~r_irq_d & w_live;
    assign w_irq_inc   = (irq_count == 8'hFF) ? 8'hFF : irq_count + 8'd1;
    assign w_to_fault  = w_irq_edge && (w_irq_inc == C_IRQ_LIMIT);
    assign w_kick_last = (r_kick_cnt == C_KICK_LAST);
    // A heartbeat on the terminal cycle rescues the FSM from starvation.
    assign w_hb_expire = !heartbeat && (r_hb_cnt == C_HB_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_kick_cnt <= 32'd0;
            r_hb_cnt   <= 32'd0;
            r_irq_d    <= 1'b0;
            pet        <= 1'b0;
            irq_count  <= 8'd0;
            fault      <= 1'b0;
        end else begin
            r_irq_d <= irq;
            pet     <= 1'b0;
            if (w_irq_edge) begin
                irq_count <= w_irq_inc;
            end
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state    <= ARMED;
                        r_kick_cnt <= 32'd0;
                        r_hb_cnt   <= 32'd0;
                    end
                end
                ARMED: begin
                    if (w_to_fault) begin
                        r_state <= FAULT;
                        fault   <= 1'b1;
                    end else if (!enable) begin
                        r_state <= IDLE;
                    end else if (w_hb_expire) begin
                        r_state <= STARVED;
                    end else begin
                        r_kick_cnt <= w_kick_last ? 32'd0 : r_kick_cnt + 32'd1;
                        r_hb_cnt   <= heartbeat ? 32'd0 : r_hb_cnt + 32'd1;
                        pet        <= w_kick_last;
                    end
                end
                STARVED: begin
                    if (w_to_fault) begin
                        r_state <= FAULT;
                        fault   <= 1'b1;
                    end else if (!enable) begin
                        r_state <= IDLE;
                    end else if (heartbeat) begin
                        r_state    <= ARMED;
                        r_kick_cnt <= 32'd0;
                        r_hb_cnt   <= 32'd0;
                    end
                end
                FAULT: begin
                    fault <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
